// File: rtl/mux4to1_sync_if.sv
// Bundle for the 4:1 synchronous channel selector. The master side drives the
// candidate bits, the select and the capture enable; the slave side (the
// selector) returns the combinational and registered views plus the counters.
interface mux4to1_sync_if #(
  parameter int CNT_W = 8
) ();

  logic             en;
  logic [3:0]       data_in;
  logic [1:0]       ctrl_sel;
  logic             data_out;
  logic             data_out_q;
  logic [1:0]       sel_q;
  logic             sel_chg;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;

  modport master (
    output en,
    output data_in,
    output ctrl_sel,
    input  data_out,
    input  data_out_q,
    input  sel_q,
    input  sel_chg,
    input  cnt0,
    input  cnt1,
    input  cnt2,
    input  cnt3
  );

  modport slave (
    input  en,
    input  data_in,
    input  ctrl_sel,
    output data_out,
    output data_out_q,
    output sel_q,
    output sel_chg,
    output cnt0,
    output cnt1,
    output cnt2,
    output cnt3
  );

endinterface

// File: rtl/mux4to1_sync.sv
// 4:1 single-bit channel selector with a zero-latency combinational output,
// a registered copy of the same selection, a select-change flag and one
// saturating selection counter per channel. Reset is synchronous and has
// priority over the capture enable; with en low every register holds.
module mux4to1_sync #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux4to1_sync_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Saturating increment: a counter already at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + CNT_ONE;
    end
    return result;
  endfunction

  // Registered state
  logic             data_out_r;
  logic [1:0]       sel_r;
  logic             sel_chg_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;
  logic [CNT_W-1:0] cnt2_r;
  logic [CNT_W-1:0] cnt3_r;

  // Next-state values for an enabled capture
  logic             sel_bit_s;
  logic             sel_chg_s;
  logic [CNT_W-1:0] cnt0_s;
  logic [CNT_W-1:0] cnt1_s;
  logic [CNT_W-1:0] cnt2_s;
  logic [CNT_W-1:0] cnt3_s;

  // Combinational selection: a plain index so an unknown select propagates
  // as unknown instead of falling back to some default channel.
  assign sel_bit_s     = bus.data_in[bus.ctrl_sel];
  assign bus.data_out  = sel_bit_s;

  // Select-change detection against the currently registered select.
  always_comb begin
    sel_chg_s = 1'b0;
    if (bus.ctrl_sel != sel_r) begin
      sel_chg_s = 1'b1;
    end else begin
      sel_chg_s = 1'b0;
    end
  end

  // Counter next-state: only the counter of the selected channel advances.
  always_comb begin
    cnt0_s = cnt0_r;
    cnt1_s = cnt1_r;
    cnt2_s = cnt2_r;
    cnt3_s = cnt3_r;
    case (bus.ctrl_sel)
      2'b00:   cnt0_s = sat_inc(cnt0_r);
      2'b01:   cnt1_s = sat_inc(cnt1_r);
      2'b10:   cnt2_s = sat_inc(cnt2_r);
      2'b11:   cnt3_s = sat_inc(cnt3_r);
      default: begin
        cnt0_s = cnt0_r;
        cnt1_s = cnt1_r;
        cnt2_s = cnt2_r;
        cnt3_s = cnt3_r;
      end
    endcase
  end

  // State update: reset first, then enabled capture, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= 1'b0;
      sel_r      <= 2'b00;
      sel_chg_r  <= 1'b0;
      cnt0_r     <= CNT_ZERO;
      cnt1_r     <= CNT_ZERO;
      cnt2_r     <= CNT_ZERO;
      cnt3_r     <= CNT_ZERO;
    end else if (bus.en) begin
      data_out_r <= sel_bit_s;
      sel_r      <= bus.ctrl_sel;
      sel_chg_r  <= sel_chg_s;
      cnt0_r     <= cnt0_s;
      cnt1_r     <= cnt1_s;
      cnt2_r     <= cnt2_s;
      cnt3_r     <= cnt3_s;
    end else begin
      data_out_r <= data_out_r;
      sel_r      <= sel_r;
      sel_chg_r  <= sel_chg_r;
      cnt0_r     <= cnt0_r;
      cnt1_r     <= cnt1_r;
      cnt2_r     <= cnt2_r;
      cnt3_r     <= cnt3_r;
    end
  end

  assign bus.data_out_q = data_out_r;
  assign bus.sel_q      = sel_r;
  assign bus.sel_chg    = sel_chg_r;
  assign bus.cnt0       = cnt0_r;
  assign bus.cnt1       = cnt1_r;
  assign bus.cnt2       = cnt2_r;
  assign bus.cnt3       = cnt3_r;

endmodule

// File: tb/tb_mux4to1_sync.sv
// Directed, table-driven bench for mux4to1_sync with 2-bit counters so that
// saturation is reached in a few cycles.
module tb_mux4to1_sync;

  logic clk;
  logic rst;

  mux4to1_sync_if #(.CNT_W(2)) bus ();

  mux4to1_sync #(.CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] di;
    logic [1:0] cs;
    logic       exp_do;
    logic       exp_q;
    logic [1:0] exp_sq;
    logic       exp_chg;
    logic [1:0] exp_c0;
    logic [1:0] exp_c1;
    logic [1:0] exp_c2;
    logic [1:0] exp_c3;
  } vec_t;

  vec_t tbl [$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [3:0] di, input logic [1:0] cs,
                     input logic edo, input logic eq, input logic [1:0] esq, input logic echg,
                     input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                     input logic [1:0] c3);
    vec_t v;
    v.rst = r; v.en = e; v.di = di; v.cs = cs;
    v.exp_do = edo; v.exp_q = eq; v.exp_sq = esq; v.exp_chg = echg;
    v.exp_c0 = c0; v.exp_c1 = c1; v.exp_c2 = c2; v.exp_c3 = c3;
    tbl.push_back(v);
  endtask

  task automatic chk_regs(input string tag, input logic eq, input logic [1:0] esq,
                          input logic echg, input logic [1:0] c0, input logic [1:0] c1,
                          input logic [1:0] c2, input logic [1:0] c3);
    chk({tag, " data_out_q"}, 8'(bus.data_out_q), 8'(eq));
    chk({tag, " sel_q"},      8'(bus.sel_q),      8'(esq));
    chk({tag, " sel_chg"},    8'(bus.sel_chg),    8'(echg));
    chk({tag, " cnt0"},       8'(bus.cnt0),       8'(c0));
    chk({tag, " cnt1"},       8'(bus.cnt1),       8'(c1));
    chk({tag, " cnt2"},       8'(bus.cnt2),       8'(c2));
    chk({tag, " cnt3"},       8'(bus.cnt3),       8'(c3));
  endtask

  initial begin
    logic [1:0] sel_steps [4];
    logic       exp_steps [4];
    checks   = 0;
    failures = 0;

    // rst, en, data_in, ctrl_sel | data_out, data_out_q, sel_q, sel_chg, cnt0..cnt3
    add(1'b1, 1'b1, 4'b1010, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0); // reset beats en
    add(1'b0, 1'b1, 4'b1010, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0); // first edge, no change
    add(1'b0, 1'b1, 4'b1010, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 2'd1, 2'd1, 2'd0, 2'd0);
    add(1'b0, 1'b1, 4'b1010, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 2'd1, 2'd1, 2'd1, 2'd0);
    add(1'b0, 1'b1, 4'b1010, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 2'd1, 2'd1, 2'd2, 2'd0); // held select
    add(1'b0, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 2'd1, 2'd1, 2'd3, 2'd0); // data change, static sel
    add(1'b0, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 2'd1, 2'd1, 2'd3, 2'd0); // cnt2 saturated
    add(1'b0, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'd1, 2'd1, 2'd3, 2'd1);
    add(1'b0, 1'b0, 4'b1111, 2'b00, 1'b1, 1'b1, 2'b11, 1'b1, 2'd1, 2'd1, 2'd3, 2'd1); // enable hold x5
    add(1'b0, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 2'd1, 2'd3, 2'd1);
    add(1'b0, 1'b0, 4'b1001, 2'b01, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 2'd1, 2'd3, 2'd1);
    add(1'b0, 1'b0, 4'b0110, 2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 2'd1, 2'd1, 2'd3, 2'd1);
    add(1'b0, 1'b0, 4'b1000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 2'd1, 2'd3, 2'd1);
    add(1'b1, 1'b0, 4'b0101, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0); // reset after activity
    add(1'b0, 1'b1, 4'b0111, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd0, 2'd0, 2'd0, 2'd1); // count ch3 x5
    add(1'b0, 1'b1, 4'b0111, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2);
    add(1'b0, 1'b1, 4'b0111, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
    add(1'b0, 1'b1, 4'b0111, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
    add(1'b0, 1'b1, 4'b0111, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
    add(1'b1, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0); // reset priority
    add(1'b0, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0); // no count while en=0
    add(1'b0, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0); // resumes

    // Combinational select with nothing registered involved.
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.data_in  = 4'b1010;
    bus.ctrl_sel = 2'b00;
    sel_steps[0] = 2'b00; exp_steps[0] = 1'b0;
    sel_steps[1] = 2'b01; exp_steps[1] = 1'b1;
    sel_steps[2] = 2'b10; exp_steps[2] = 1'b0;
    sel_steps[3] = 2'b11; exp_steps[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ctrl_sel = sel_steps[i];
      #10;
      chk($sformatf("comb sel=%0d data_out", i), 8'(bus.data_out), 8'(exp_steps[i]));
    end

    // Table: drive away from the edge, check #1 after the edge.
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst          = tbl[i].rst;
      bus.en       = tbl[i].en;
      bus.data_in  = tbl[i].di;
      bus.ctrl_sel = tbl[i].cs;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d data_out", i), 8'(bus.data_out), 8'(tbl[i].exp_do));
      chk_regs($sformatf("v%0d", i), tbl[i].exp_q, tbl[i].exp_sq, tbl[i].exp_chg,
               tbl[i].exp_c0, tbl[i].exp_c1, tbl[i].exp_c2, tbl[i].exp_c3);
    end

    // Mid-cycle: simultaneous data/select change shows at once on data_out only.
    bus.data_in  = 4'b0100;
    bus.ctrl_sel = 2'b10;
    #2;
    chk("mid pair data_out", 8'(bus.data_out), 8'd1);
    chk("mid pair data_out_q", 8'(bus.data_out_q), 8'd1);
    chk("mid pair sel_q", 8'(bus.sel_q), 8'd1);
    bus.data_in = 4'b0000;
    #2;
    chk("mid data data_out", 8'(bus.data_out), 8'd0);
    chk("mid data data_out_q", 8'(bus.data_out_q), 8'd1);
    @(posedge clk);
    #1;
    chk_regs("after mid", 1'b0, 2'b10, 1'b1, 2'd0, 2'd1, 2'd1, 2'd0);

    // data_out keeps working while reset is held.
    rst          = 1'b1;
    bus.data_in  = 4'b1000;
    bus.ctrl_sel = 2'b11;
    @(posedge clk);
    #1;
    chk("in reset data_out", 8'(bus.data_out), 8'd1);
    chk_regs("in reset", 1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
